// File: rtl/spike_decoder.sv
// Spike-train decoder: counts spike events per programmable window (rate, with
// valid/ready hand-off and sticky overflow flag) and measures inter-spike intervals.
module spike_decoder #(
  parameter int RATE_W = 8,
  parameter int ISI_W  = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              spike_in,
  input  logic [7:0]        window_len,
  input  logic              lost_clr,
  output logic [RATE_W-1:0] rate,
  output logic              rate_valid,
  input  logic              rate_ready,
  output logic [ISI_W-1:0]  isi,
  output logic              isi_valid,
  output logic              lost
);

  // state | meaning
  // IDLE  | decoding halted, waiting for enable; rate hand-off still served
  // COUNT | window counter running, events counted, ISI measured
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] COUNT = 1'b1;

  logic [0:0]       state;
  logic             spike_prev;
  logic [8:0]       win_cnt;
  logic [7:0]       evt_cnt;
  logic [ISI_W-1:0] isi_cnt;
  logic             isi_armed;

  logic       spike_evt;
  logic       win_end;
  logic       handshake;
  logic       load_rate;
  logic       lost_set;
  logic [8:0] win_load;
  logic [7:0] evt_next;

  assign spike_evt = spike_in & ~spike_prev;
  assign win_end   = (state == COUNT) & enable & (win_cnt == 9'd1);
  assign handshake = rate_valid & rate_ready;
  assign load_rate = win_end & (~rate_valid | rate_ready);
  assign lost_set  = win_end & rate_valid & ~rate_ready;
  assign win_load  = (window_len == 8'd0) ? 9'd256 : {1'b0, window_len};
  // Events need a low cycle between them, so at most 128 per window: 8 bits suffice.
  assign evt_next  = evt_cnt + {7'd0, spike_evt};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      spike_prev <= 1'b0;
      win_cnt    <= 9'd0;
      evt_cnt    <= 8'd0;
      isi_cnt    <= '0;
      isi_armed  <= 1'b0;
      rate       <= '0;
      rate_valid <= 1'b0;
      isi        <= '0;
      isi_valid  <= 1'b0;
      lost       <= 1'b0;
    end else begin
      spike_prev <= spike_in;
      isi_valid  <= 1'b0;

      if (load_rate) begin
        rate       <= RATE_W'(evt_next);
        rate_valid <= 1'b1;
      end else if (handshake) begin
        rate_valid <= 1'b0;
      end

      if (lost_set)
        lost <= 1'b1;
      else if (lost_clr)
        lost <= 1'b0;

      case (state)
        IDLE: begin
          if (enable) begin
            state     <= COUNT;
            win_cnt   <= win_load;
            evt_cnt   <= 8'd0;
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
          end
        end
        COUNT: begin
          if (!enable) begin
            state     <= IDLE;
            win_cnt   <= 9'd0;
            evt_cnt   <= 8'd0;
            isi_cnt   <= '0;
            isi_armed <= 1'b0;
          end else begin
            // Reload on the final edge so the next window starts with no gap.
            if (win_end) begin
              win_cnt <= win_load;
              evt_cnt <= 8'd0;
            end else begin
              win_cnt <= win_cnt - 9'd1;
              evt_cnt <= evt_next;
            end

            if (spike_evt) begin
              isi_cnt   <= ISI_W'(1);
              isi_armed <= 1'b1;
              if (isi_armed) begin
                isi       <= isi_cnt;
                isi_valid <= 1'b1;
              end
            end else if (isi_cnt != '1) begin
              isi_cnt <= isi_cnt + ISI_W'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spike_decoder.sv
// Directed, table-driven bench for spike_decoder: one vector per clock edge,
// plus hand-written sequences for async reset and long windows/intervals.
module tb_spike_decoder;

  logic       clk;
  logic       rst_n;
  logic       enable;
  logic       spike_in;
  logic [7:0] window_len;
  logic       lost_clr;
  logic [7:0] rate;
  logic       rate_valid;
  logic       rate_ready;
  logic [7:0] isi;
  logic       isi_valid;
  logic       lost;

  int errors = 0;
  int checks = 0;

  spike_decoder #(.RATE_W(8), .ISI_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .spike_in   (spike_in),
    .window_len (window_len),
    .lost_clr   (lost_clr),
    .rate       (rate),
    .rate_valid (rate_valid),
    .rate_ready (rate_ready),
    .isi        (isi),
    .isi_valid  (isi_valid),
    .lost       (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       en;
    logic       sp;
    logic       rdy;
    logic       clr;
    logic [7:0] wl;
    logic [7:0] rate;
    logic       rv;
    logic [7:0] isi;
    logic       iv;
    logic       lost;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic en, input logic sp, input logic rdy, input logic clr,
                              input logic [7:0] wl, input logic [7:0] r, input logic rv,
                              input logic [7:0] i, input logic iv, input logic l);
    vec_t v;
    v.en = en; v.sp = sp; v.rdy = rdy; v.clr = clr; v.wl = wl;
    v.rate = r; v.rv = rv; v.isi = i; v.iv = iv; v.lost = l;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] outs();
    return {13'd0, rate, rate_valid, isi, isi_valid, lost};
  endfunction

  initial begin
    rst_n = 1'b0; enable = 1'b0; spike_in = 1'b0; window_len = 8'd10;
    lost_clr = 1'b0; rate_ready = 1'b0;

    //   en sp rdy clr wl   | rate rv isi iv lost
    // 10-edge window, pulses on edges 1,4,7,10
    add(1, 0, 0, 0, 10,   0, 0,  0, 0, 0);  // load
    add(1, 1, 0, 0, 10,   0, 0,  0, 0, 0);  // e1 first event: arm only
    add(1, 0, 0, 0, 10,   0, 0,  0, 0, 0);
    add(1, 0, 0, 0, 10,   0, 0,  0, 0, 0);
    add(1, 1, 0, 0, 10,   0, 0,  3, 1, 0);  // e4
    add(1, 0, 0, 0, 10,   0, 0,  3, 0, 0);
    add(1, 0, 0, 0, 10,   0, 0,  3, 0, 0);
    add(1, 1, 0, 0, 10,   0, 0,  3, 1, 0);  // e7
    add(1, 0, 0, 0, 10,   0, 0,  3, 0, 0);
    add(1, 0, 0, 0, 10,   0, 0,  3, 0, 0);
    add(1, 1, 0, 0, 10,   4, 1,  3, 1, 0);  // e10 window end, last-edge event counted
    // next window: consume, then a 5-cycle high level = one event
    add(1, 0, 1, 0, 10,   4, 0,  3, 0, 0);  // e11
    add(1, 1, 0, 0, 10,   4, 0,  2, 1, 0);  // e12
    add(1, 1, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 1, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 1, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 1, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 0, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 0, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 0, 0, 0, 10,   4, 0,  2, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1,  2, 0, 0);  // e20
    // third window aborted at edge 6
    add(1, 0, 0, 0, 10,   1, 1,  2, 0, 0);
    add(1, 1, 0, 0, 10,   1, 1, 10, 1, 0);  // e22
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(0, 0, 0, 0, 10,   1, 1, 10, 0, 0);  // edge 6: back to IDLE
    add(0, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);  // re-enable load
    add(1, 1, 0, 0, 10,   1, 1, 10, 0, 0);  // k1 arm only after re-entry
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0, 10,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0,  4,   1, 1, 10, 0, 0);  // k5: length change waits for next load
    add(1, 0, 0, 0,  4,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0,  4,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0,  4,   1, 1, 10, 0, 0);
    add(1, 0, 0, 0,  4,   1, 1, 10, 0, 0);  // k9
    add(1, 1, 1, 0,  4,   2, 1,  9, 1, 0);  // k10 handshake + reload same edge
    // 4-edge windows: counts 2 then 1 with no consumer
    add(1, 0, 1, 0,  4,   2, 0,  9, 0, 0);  // f1
    add(1, 1, 0, 0,  4,   2, 0,  2, 1, 0);
    add(1, 0, 0, 0,  4,   2, 0,  2, 0, 0);
    add(1, 1, 0, 0,  4,   2, 1,  2, 1, 0);  // f4
    add(1, 0, 0, 0,  4,   2, 1,  2, 0, 0);
    add(1, 1, 0, 0,  4,   2, 1,  2, 1, 0);
    add(1, 0, 0, 0,  4,   2, 1,  2, 0, 0);
    add(1, 0, 0, 0,  4,   2, 1,  2, 0, 1);  // g4 discarded -> lost
    add(1, 0, 1, 0,  4,   2, 0,  2, 0, 1);
    add(1, 0, 0, 1,  4,   2, 0,  2, 0, 0);  // lost_clr
    add(1, 0, 0, 0,  4,   2, 0,  2, 0, 0);
    add(1, 0, 0, 0,  4,   0, 1,  2, 0, 0);  // h4 empty window
    add(1, 0, 0, 0,  4,   0, 1,  2, 0, 0);
    add(1, 0, 0, 0,  4,   0, 1,  2, 0, 0);
    add(1, 0, 0, 0,  4,   0, 1,  2, 0, 0);
    add(1, 0, 0, 1,  4,   0, 1,  2, 0, 1);  // set beats clear
    add(1, 0, 0, 0,  4,   0, 1,  2, 0, 1);

    #2;
    chk("reset_outputs", outs(), 32'd0);
    #8 rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      enable = vecs[i].en; spike_in = vecs[i].sp; rate_ready = vecs[i].rdy;
      lost_clr = vecs[i].clr; window_len = vecs[i].wl;
      @(posedge clk); #1;
      chk($sformatf("vec[%0d]", i), outs(),
          {13'd0, vecs[i].rate, vecs[i].rv, vecs[i].isi, vecs[i].iv, vecs[i].lost});
    end

    // async reset mid-window with rate_valid=1
    enable = 1'b1; spike_in = 1'b0; rate_ready = 1'b0; lost_clr = 1'b0;
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_reset", outs(), 32'd0);
    #2 rst_n = 1'b1;
    enable = 1'b0;
    for (int n = 0; n < 6; n++) begin
      spike_in = n[0];
      @(posedge clk); #1;
    end
    chk("no_count_without_enable", outs(), 32'd0);

    // window_len=0 means 256 edges; long gap saturates isi
    window_len = 8'd0; enable = 1'b1; spike_in = 1'b0;
    @(posedge clk); #1;
    for (int n = 1; n <= 301; n++) begin
      spike_in = (n == 1 || n == 301);
      @(posedge clk); #1;
      if (n == 1)   chk("first_event_no_isi", {31'd0, isi_valid}, 32'd0);
      if (n == 255) chk("win256_not_early", {31'd0, rate_valid}, 32'd0);
      if (n == 256) chk("win256_end", {23'd0, rate, rate_valid}, {23'd0, 8'd1, 1'b1});
      if (n == 301) chk("isi_saturate", {23'd0, isi, isi_valid}, {23'd0, 8'd255, 1'b1});
    end
    spike_in = 1'b0;
    @(posedge clk); #1;
    chk("isi_valid_one_cycle", {31'd0, isi_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spike_decoder.md
SPIKE_DECODER -- requirements
Module: spike_decoder

Interface
REQ-001 SHALL have parameter RATE_W, default 8, width of the rate result.
REQ-002 SHALL have parameter ISI_W, default 8, width of the inter-spike-interval result.
REQ-003 clk  input  1  single clock, all state on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert and active-low.
REQ-005 enable  input  1  1 = decoding runs; 0 = return to IDLE.
REQ-006 spike_in  input  1  spike train from a neuron, one-cycle pulses nominal.
REQ-007 window_len  input  8  rate window length in clock edges; 0 means 256.
REQ-008 lost_clr  input  1  synchronous clear of the lost flag.
REQ-009 rate  output  RATE_W  spike count of the last completed window.
REQ-010 rate_valid  output  1  rate holds an unconsumed result.
REQ-011 rate_ready  input  1  consumer accepts rate when rate_valid & rate_ready.
REQ-012 isi  output  ISI_W  clock edges between the two most recent spike events.
REQ-013 isi_valid  output  1  one-cycle strobe, new isi value.
REQ-014 lost  output  1  sticky: a window result was discarded.

Function
REQ-015 SHALL define a spike event as spike_in=1 at an edge with spike_prev=0, where spike_prev is spike_in registered on the previous edge; a level held high N cycles is one event.
REQ-016 SHALL implement FSM states IDLE and COUNT.
REQ-017 IDLE: on an edge with enable=1, SHALL go to COUNT, load the window counter from window_len (0 loads 256), and clear the event count and ISI history.
REQ-018 COUNT: SHALL decrement the window counter on every edge and add 1 to the event count for each event on that edge.
REQ-019 The window SHALL span exactly window_len edges in COUNT; an event on the last edge SHALL be included.
REQ-020 At window end, if rate_valid=0 or a handshake occurs on the same edge, SHALL load rate with the count and set rate_valid=1 on that edge.
REQ-021 At window end with rate_valid=1 and rate_ready=0, SHALL keep rate unchanged, discard the new count, and set lost=1.
REQ-022 SHALL restart the next window on the edge after window end, with the count cleared, sampling window_len again; the next window has no dead cycles.
REQ-023 rate SHALL remain stable while rate_valid=1; rate_valid SHALL clear on a handshake edge unless REQ-020 reloads it.
REQ-024 The event count cannot exceed 128 per window because events need a low cycle between them; RATE_W=8 SHALL therefore never wrap.
REQ-025 ISI counter: SHALL increment every COUNT edge, saturating at 2^ISI_W-1, and reset to 1 on the edge after each event.
REQ-026 On each event after the first since entering COUNT, SHALL load isi with the ISI counter value (events at edges t1 and t2 give t2-t1, saturated) and pulse isi_valid for exactly one cycle.
REQ-027 The first event after entering COUNT SHALL only arm the ISI counter, with no isi_valid.
REQ-028 enable=0 in COUNT SHALL go to IDLE on that edge and discard the partial count and ISI history; rate, rate_valid, isi and lost SHALL be retained.
REQ-029 In IDLE, rate_valid handshakes SHALL still be honoured.
REQ-030 lost_clr=1 SHALL clear lost; if a set (REQ-021) and lost_clr occur on the same edge, set SHALL win.
REQ-031 window_len changes mid-window SHALL take effect only at the next window load.

Reset
REQ-032 rst_n=0 SHALL immediately, without waiting for a clock edge, force: FSM=IDLE, rate=0, rate_valid=0, isi=0, isi_valid=0, lost=0, spike_prev=0, and all counters=0.
REQ-033 Reset deassertion SHALL require a clk edge with enable=1 before counting starts; behaviour is then identical to a fresh enable.

Verification
REQ-034 window_len=10, enable held, single-cycle pulses on edges 1,4,7,10 of the window -> after edge 10: rate=4, rate_valid=1; next window starts on edge 11.
REQ-035 window_len=10, spike_in held high 5 cycles inside the window -> rate=1.
REQ-036 Events on COUNT edges 5 and 12 -> isi=7 with isi_valid high for one cycle after edge 12; no isi_valid after edge 5. Events 300 edges apart -> isi=255.
REQ-037 window_len=4, rate_ready=0 across two windows with counts 2 then 1 -> rate stays 2, lost=1; rate_ready=1 for one cycle -> rate_valid=0; lost_clr -> lost=0.
REQ-038 rst_n pulled low mid-window with rate_valid=1 -> all outputs 0 before the next clk edge; after release, no counting until enable is sampled high.
REQ-039 enable dropped at window edge 6 of 10 -> no rate update, previous rate/rate_valid retained; re-enable -> full 10-edge window from zero.
